// File: rtl/hex_display_capture.sv
// Purpose: decodes a multi-digit seven-segment bus, debounces it and queues each new stable value in a FWFT FIFO.
// Latency: a pattern first sampled at edge k is visible on out_valid/out_value after edge k+STABLE_CYCLES.
// Backpressure: out_valid/out_ready read port; a value accepted while full with no pop is dropped and sets overflow.
module hex_display_capture #(
    parameter int DIGITS        = 4,
    parameter int DEPTH         = 8,
    parameter int STABLE_CYCLES = 4,
    parameter int ACTIVE_LOW    = 1,
    parameter int SKIP_INVALID  = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [7*DIGITS-1:0]          hex,
    input  logic                         clear,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [4*DIGITS-1:0]          out_value,
    output logic [DIGITS-1:0]            out_invalid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int EW = 5 * DIGITS;

    // Segment pattern (active-high, bit 0 = segment a) to {invalid, nibble}.
    function automatic logic [4:0] f_decode(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'h3F:   res = 5'h00;
            7'h06:   res = 5'h01;
            7'h5B:   res = 5'h02;
            7'h4F:   res = 5'h03;
            7'h66:   res = 5'h04;
            7'h6D:   res = 5'h05;
            7'h7D:   res = 5'h06;
            7'h07:   res = 5'h07;
            7'h7F:   res = 5'h08;
            7'h6F:   res = 5'h09;
            7'h77:   res = 5'h0A;
            7'h7C:   res = 5'h0B;
            7'h39:   res = 5'h0C;
            7'h5E:   res = 5'h0D;
            7'h79:   res = 5'h0E;
            7'h71:   res = 5'h0F;
            default: res = 5'h10;
        endcase
        return res;
    endfunction

    logic [7*DIGITS-1:0] r_hex_q;
    logic [SW-1:0]       r_cnt;
    logic [7*DIGITS-1:0] r_last;
    logic                r_have_last;

    logic [EW-1:0]       r_mem [DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic                r_overflow;

    logic [4*DIGITS-1:0] w_nib;
    logic [DIGITS-1:0]   w_inv;
    logic                w_same;
    logic                w_accept;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_push;
    logic [EW-1:0]       w_head;

    // Decode the sampled pattern digit by digit; the accept edge requires hex==hex_q, so this is the accepted value.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        logic [6:0] w_seg;
        logic [4:0] w_dec;
        assign w_seg = (ACTIVE_LOW != 0) ? ~r_hex_q[7*gi +: 7] : r_hex_q[7*gi +: 7];
        assign w_dec = f_decode(w_seg);
        assign w_nib[4*gi +: 4] = w_dec[3:0];
        assign w_inv[gi]        = w_dec[4];
    end

    assign w_same   = (hex == r_hex_q);
    assign w_accept = w_same
                   && (r_cnt == SW'(STABLE_CYCLES - 1))
                   && (!r_have_last || (r_hex_q != r_last))
                   && !((SKIP_INVALID != 0) && (|w_inv));

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && out_ready;
    assign w_push  = w_accept && (!w_full || w_pop);

    // Track the incoming pattern and count how long it has held; the counter saturates so one hold accepts once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hex_q <= '0;
            r_cnt   <= '0;
        end else if (!w_same) begin
            r_hex_q <= hex;
            r_cnt   <= '0;
        end else if (r_cnt != SW'(STABLE_CYCLES)) begin
            r_cnt <= r_cnt + SW'(1);
        end
    end

    // Remember the last accepted pattern so a value repeated after a glitch is not queued twice.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last      <= '0;
            r_have_last <= 1'b0;
        end else if (clear) begin
            r_have_last <= 1'b0;
        end else if (w_accept) begin
            r_last      <= r_hex_q;
            r_have_last <= 1'b1;
        end
    end

    // FIFO storage; stale contents are masked by out_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (rst_n && !clear && w_push) begin
            r_mem[r_wr_ptr] <= {w_inv, w_nib};
        end
    end

    // FIFO pointers, occupancy and sticky overflow; clear wins over push and pop.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
            if (w_accept && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_head      = w_empty ? '0 : r_mem[r_rd_ptr];
    assign out_valid   = !w_empty;
    assign out_value   = w_head[4*DIGITS-1:0];
    assign out_invalid = w_head[EW-1:4*DIGITS];
    assign count       = r_count;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_hex_display_capture.sv
// Purpose: self-checking bench for hex_display_capture using a scoreboard of expected FIFO entries.
// Latency: expected entries are queued when a stable hold is driven and compared when the DUT pops them.
// Backpressure: out_ready is driven per scenario; a second instance with SKIP_INVALID=1 always drains.
module tb_hex_display_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [27:0] hex;
    logic        clear;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_value;
    logic [3:0]  out_invalid;
    logic [2:0]  count;
    logic        overflow;

    logic        out_valid2;
    logic [15:0] out_value2;
    logic [3:0]  out_invalid2;
    logic [2:0]  count2;
    logic        overflow2;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [19:0] sb_q[$];
    logic        mon2_en = 1'b0;
    int          seen2 = 0;

    always #5 clk = ~clk;

    hex_display_capture #(
        .DIGITS(4), .DEPTH(4), .STABLE_CYCLES(4), .ACTIVE_LOW(1), .SKIP_INVALID(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hex(hex), .clear(clear), .out_ready(out_ready),
        .out_valid(out_valid), .out_value(out_value), .out_invalid(out_invalid),
        .count(count), .overflow(overflow)
    );

    hex_display_capture #(
        .DIGITS(4), .DEPTH(4), .STABLE_CYCLES(4), .ACTIVE_LOW(1), .SKIP_INVALID(1)
    ) dut_skip (
        .clk(clk), .rst_n(rst_n), .hex(hex), .clear(clear), .out_ready(1'b1),
        .out_valid(out_valid2), .out_value(out_value2), .out_invalid(out_invalid2),
        .count(count2), .overflow(overflow2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Active-low bus for a 4-digit hex value, digit 3 most significant.
    function automatic logic [27:0] enc(input logic [15:0] v);
        return ~{seg(v[15:12]), seg(v[11:8]), seg(v[7:4]), seg(v[3:0])};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [27:0] pat, input int n);
        hex = pat;
        repeat (n) tick();
    endtask

    // Compare each popped entry against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && !clear && out_valid && out_ready) begin
            check("sb_avail", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                logic [19:0] e;
                e = sb_q.pop_front();
                check("pop_value", 32'(out_value), 32'(e[15:0]));
                check("pop_invalid", 32'(out_invalid), 32'(e[19:16]));
            end
        end
        if (mon2_en && out_valid2) seen2++;
    end

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        hex       = enc(16'h0123);
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_value", 32'(out_value), 32'd0);
        check("rst_invalid", 32'(out_invalid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        // Latency: first sampled at edge k, visible after edge k+4.
        rst_n = 1'b1;
        sb_q.push_back({4'b0000, 16'h0123});
        repeat (4) tick();
        check("lat_early", 32'(out_valid), 32'd0);
        tick();
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_value", 32'(out_value), 32'h0123);
        check("lat_invalid", 32'(out_invalid), 32'd0);
        check("lat_count", 32'(count), 32'd1);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("drain1_count", 32'(count), 32'd0);

        // Glitches and a repeat of the last value produce no entry.
        hold(enc(16'h4567), 2);
        hold(enc(16'h0123), 6);
        for (int g = 1; g <= 4; g++) begin
            hold(enc(16'h9999), g);
            hold(enc(16'h0123), 6);
        end
        check("glitch_count", 32'(count), 32'd0);

        // Overflow: five stable values, depth four, no reads.
        hold(enc(16'h1111), 6); sb_q.push_back({4'b0, 16'h1111});
        hold(enc(16'h2222), 6); sb_q.push_back({4'b0, 16'h2222});
        hold(enc(16'h3333), 6); sb_q.push_back({4'b0, 16'h3333});
        hold(enc(16'h4444), 6); sb_q.push_back({4'b0, 16'h4444});
        hold(enc(16'h5555), 6);
        check("ovf_count", 32'(count), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        check("ovf_drain_count", 32'(count), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Clear with three entries and overflow set.
        hold(enc(16'h6666), 6);
        hold(enc(16'h7777), 6);
        hold(enc(16'h8888), 6);
        check("pre_clr_count", 32'(count), 32'd3);
        check("pre_clr_ovf", 32'(overflow), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        mon2_en = 1'b1;
        check("clr_count", 32'(count), 32'd0);
        check("clr_valid", 32'(out_valid), 32'd0);
        check("clr_ovf", 32'(overflow), 32'd0);
        hold(enc(16'h8888), 6);
        check("clr_norepush", 32'(count), 32'd0);

        // Blank digit 0: flagged entry normally, nothing with SKIP_INVALID.
        sb_q.push_back({4'b0001, 16'h8880});
        hold(~{seg(4'h8), seg(4'h8), seg(4'h8), 7'h00}, 6);
        check("blank_count", 32'(count), 32'd1);
        check("blank_value", 32'(out_value), 32'h8880);
        check("blank_invalid", 32'(out_invalid), 32'b0001);
        check("skip_count", 32'(count2), 32'd0);
        check("skip_seen", 32'(seen2), 32'd0);
        mon2_en = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Full FIFO with a pop on the accept edge.
        hold(enc(16'hA111), 6); sb_q.push_back({4'b0, 16'hA111});
        hold(enc(16'hA222), 6); sb_q.push_back({4'b0, 16'hA222});
        hold(enc(16'hA333), 6); sb_q.push_back({4'b0, 16'hA333});
        hold(enc(16'hA444), 6); sb_q.push_back({4'b0, 16'hA444});
        check("full_count", 32'(count), 32'd4);
        sb_q.push_back({4'b0, 16'hA555});
        hold(enc(16'hA555), 4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("fullpop_count", 32'(count), 32'd4);
        check("fullpop_ovf", 32'(overflow), 32'd0);
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        check("fullpop_drain", 32'(count), 32'd0);

        // Reset mid-stream, one edge before the next accept.
        hold(enc(16'hB111), 6);
        check("pre_rst_count", 32'(count), 32'd1);
        hold(enc(16'hB222), 4);
        rst_n = 1'b0;
        tick();
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_value", 32'(out_value), 32'd0);
        check("mrst_invalid", 32'(out_invalid), 32'd0);
        check("mrst_count", 32'(count), 32'd0);
        check("mrst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        tick();
        check("sb_left", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
